trail_backtracker: RTL

TRAIL_BACKTRACKER -- requirements
Module: trail_backtracker

---
 rtl/trail_backtracker_pkg.sv | 24 ++
 rtl/trail_backtracker.sv | 115 +++++++++++
 2 files changed

// File: rtl/trail_backtracker_pkg.sv
// rtl/trail_backtracker_pkg.sv - shared widths, trail entry layout and FSM states for the trail backtracker
package trail_backtracker_pkg;

    localparam int VAR_W           = 8;
    localparam int BOOL_STACK_SIZE = 16;
    localparam int DEPTH_W         = $clog2(BOOL_STACK_SIZE + 1);
    localparam int ENTRY_W         = VAR_W + 2;

    typedef struct packed {
        logic             is_dec;
        logic [VAR_W-1:0] var_id;
        logic             val;
    } trail_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_EMIT  = 3'd4,
        ST_UNSAT = 3'd5
    } bt_state_e;

endpackage

// File: rtl/trail_backtracker.sv
// rtl/trail_backtracker.sv - pushes assignments onto an external trail stack and unwinds it to the last decision on conflict
module trail_backtracker
    import trail_backtracker_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               assign_valid,
    input  logic [VAR_W-1:0]   assign_var,
    input  logic               assign_val,
    input  logic               assign_is_dec,
    output logic               assign_ready,
    input  logic               conflict,
    output logic               bt_valid,
    output logic [VAR_W-1:0]   bt_var,
    output logic               bt_val,
    input  logic               bt_ready,
    output logic [DEPTH_W-1:0] bt_depth,
    output logic               unassign_valid,
    output logic [VAR_W-1:0]   unassign_var,
    output logic               unsat,
    output logic               stk_push,
    output logic               stk_pop,
    output logic [ENTRY_W-1:0] stk_din,
    input  logic [ENTRY_W-1:0] stk_dout,
    input  logic               stk_full,
    input  logic               stk_empty
);

    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] POP   = ST_POP;
    localparam logic [2:0] WAIT  = ST_WAIT;
    localparam logic [2:0] CHECK = ST_CHECK;
    localparam logic [2:0] EMIT  = ST_EMIT;
    localparam logic [2:0] UNSAT = ST_UNSAT;

    logic [2:0]   state;
    trail_entry_t top_entry;
    logic         assign_fire;
    logic         flip_fire;

    assign top_entry = trail_entry_t'(stk_dout);

    // Stack strobes are combinational for zero-latency pushes, so they are
    // gated by reset to keep the stack quiet the instant reset asserts.
    assign assign_ready = !reset && (state == IDLE) && !stk_full && !conflict;
    assign assign_fire  = assign_valid && assign_ready;
    assign flip_fire    = !reset && (state == EMIT) && bt_ready;
    assign stk_push     = assign_fire || flip_fire;
    assign stk_pop      = !reset && (state == POP) && !stk_empty;

    always_comb begin
        stk_din = '0;
        if (assign_fire) begin
            stk_din = {assign_is_dec, assign_var, assign_val};
        end else if (flip_fire) begin
            stk_din = {1'b0, bt_var, bt_val};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            bt_valid       <= 1'b0;
            bt_var         <= '0;
            bt_val         <= 1'b0;
            bt_depth       <= '0;
            unassign_valid <= 1'b0;
            unassign_var   <= '0;
            unsat          <= 1'b0;
        end else begin
            unassign_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (conflict) begin
                        bt_depth <= '0;
                        state    <= POP;
                    end
                end
                POP: begin
                    if (stk_empty) begin
                        unsat <= 1'b1;
                        state <= UNSAT;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: state <= CHECK;
                CHECK: begin
                    unassign_valid <= 1'b1;
                    unassign_var   <= top_entry.var_id;
                    if (bt_depth != '1) begin
                        bt_depth <= bt_depth + DEPTH_W'(1);
                    end
                    if (top_entry.is_dec) begin
                        bt_valid <= 1'b1;
                        bt_var   <= top_entry.var_id;
                        bt_val   <= !top_entry.val;
                        state    <= EMIT;
                    end else begin
                        state <= POP;
                    end
                end
                EMIT: begin
                    if (bt_ready) begin
                        bt_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                UNSAT: unsat <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
